seg7_scan_decoder: RTL and testbench

- Receive-side decoder for the team's multiplexed 4-digit common-anode seven-segment bus (active-low segments, active-low anodes).
- Samples the scanned seg/an lines and filters out scan-transition glitches with a stability counter.
- Inverts the hex glyph table back to 4-bit values and maintains a 4-digit readback register with per-digit valid, frame-complete pulse and error reporting.
- Used for self-check/readback of display drivers and in loopback benches.

---
 rtl/seg7_scan_decoder.sv | 187 ++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: reads back a scanned 4-digit active-low seven-segment bus into hex digits with error flags.
// Latency: a capture lands STABLE_CYCLES edges after the last input change; pulses are one cycle wide.
// No backpressure (input is sampled every cycle); optional watchdog enabled by defining SEG7_TIMEOUT_EN.
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic        capture,
  output logic        frame_done,
  output logic        code_err,
  output logic        sel_err,
  output logic [7:0]  err_count,
  output logic        stale
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

  localparam logic [7:0] STABLE_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_stable
    $error("seg7_scan_decoder: STABLE_CYCLES must be within 1..255");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("seg7_scan_decoder: TIMEOUT_CYCLES must be at least 1");
  end

  // Exact-match inverse of the hex glyph table: {legal, value}.
  function automatic logic [4:0] glyph_lookup(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h10:   r = {1'b1, 4'h9};
      7'h08:   r = {1'b1, 4'hA};
      7'h03:   r = {1'b1, 4'hB};
      7'h46:   r = {1'b1, 4'hC};
      7'h21:   r = {1'b1, 4'hD};
      7'h06:   r = {1'b1, 4'hE};
      7'h0E:   r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  logic [6:0] s_seg;
  logic [3:0] s_an;
  logic [7:0] stab_cnt;
  state_t     state;
  logic [3:0] seen;

  logic       same;
  logic       fire;
  logic [3:0] sel;
  logic       sel_one;
  logic       sel_multi;
  logic [4:0] glyph;
  logic       glyph_ok;
  logic [3:0] glyph_val;
  logic       blank;
  logic       accept;
  logic [3:0] seen_next;
  logic       wd_fire;

  always_comb begin
    same      = ({seg, an} == {s_seg, s_an});
    // The capture edge is the one on which the count would reach STABLE_CYCLES.
    fire      = (state == SETTLE) && same && (stab_cnt == STABLE_LAST);
    sel       = ~s_an;
    sel_one   = (sel != 4'h0) && ((sel & (sel - 4'd1)) == 4'h0);
    sel_multi = (sel != 4'h0) && !sel_one;
    glyph     = glyph_lookup(s_seg);
    glyph_ok  = glyph[4];
    glyph_val = glyph[3:0];
    blank     = (s_seg == 7'h7F);
    accept    = fire && sel_one && (glyph_ok || blank);
    seen_next = seen | sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg       <= 7'h7F;
      s_an        <= 4'hF;
      stab_cnt    <= 8'd0;
      state       <= IDLE;
      seen        <= 4'h0;
      digits      <= 16'h0000;
      digit_valid <= 4'h0;
      capture     <= 1'b0;
      frame_done  <= 1'b0;
      code_err    <= 1'b0;
      sel_err     <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      s_seg      <= seg;
      s_an       <= an;
      capture    <= 1'b0;
      frame_done <= 1'b0;
      code_err   <= 1'b0;

      if (!same) begin
        stab_cnt <= 8'd0;
        state    <= SETTLE;
      end else begin
        if (stab_cnt != STABLE_MAX)
          stab_cnt <= stab_cnt + 8'd1;
        if (fire)
          state <= CAPTURED;
      end

      if (fire) begin
        if (sel_multi) begin
          sel_err <= 1'b1;
        end else if (sel_one && !glyph_ok && !blank) begin
          code_err <= 1'b1;
          if (err_count != 8'hFF)
            err_count <= err_count + 8'd1;
        end
      end

      if (accept) begin
        capture <= 1'b1;
        for (int i = 0; i < 4; i++) begin
          if (sel[i]) begin
            if (glyph_ok) begin
              digits[4*i +: 4] <= glyph_val;
              digit_valid[i]   <= 1'b1;
            end else begin
              digit_valid[i]   <= 1'b0;
            end
          end
        end
        if (seen_next == 4'hF) begin
          frame_done <= 1'b1;
          seen       <= 4'h0;
        end else begin
          seen       <= seen_next;
        end
      end else if (wd_fire) begin
        digit_valid <= 4'h0;
        seen        <= 4'h0;
      end
    end
  end

`ifdef SEG7_TIMEOUT_EN
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] wd_cnt;
  logic        stale_q;

  // A capture on the same edge as expiry wins; the counter parks once stale.
  assign wd_fire = !accept && !stale_q && (wd_cnt == WD_LAST);
  assign stale   = stale_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt  <= 32'd0;
      stale_q <= 1'b0;
    end else if (accept) begin
      wd_cnt  <= 32'd0;
      stale_q <= 1'b0;
    end else if (!stale_q) begin
      wd_cnt  <= wd_cnt + 32'd1;
      if (wd_fire)
        stale_q <= 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign stale   = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: history-window reference model compared every cycle, plus directed literal checks.
module tb_seg7_scan_decoder;

  localparam int S  = 4;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        capture;
  logic        frame_done;
  logic        code_err;
  logic        sel_err;
  logic [7:0]  err_count;
  logic        stale;

  seg7_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .seg(seg), .an(an),
    .digits(digits), .digit_valid(digit_valid), .capture(capture),
    .frame_done(frame_done), .code_err(code_err), .sel_err(sel_err),
    .err_count(err_count), .stale(stale)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_checks = 0;
  int n_fail   = 0;
  int cap_cnt  = 0;
  int frame_cnt = 0;
  int cerr_cnt = 0;
  bit ready    = 1'b0;

  // Reference state
  logic [10:0] hist [$];
  logic [3:0]  m_dig [4];
  bit          m_val [4];
  bit          m_seen [4];
  int          m_err;
  bit          m_sel, m_cap, m_frame, m_cerr, m_stale;
  int          m_since;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Capture at edge t iff the inputs at edges t-S..t are equal and differ from the one at t-S-1.
  task automatic model_step(input logic r, input logic [6:0] sg, input logic [3:0] a);
    bit fire, accepted, all_seen;
    int nlow, idx, gv;
    m_cap = 0; m_frame = 0; m_cerr = 0;
    if (r) begin
      for (int i = 0; i < 4; i++) begin m_dig[i] = 4'h0; m_val[i] = 0; m_seen[i] = 0; end
      m_err = 0; m_sel = 0; m_stale = 0; m_since = 0;
      hist.delete();
      for (int i = 0; i < S + 2; i++) hist.push_back(11'h7FF);
      ready = 1'b1;
      return;
    end
    if (!ready) return;
    hist.push_back({sg, a});
    void'(hist.pop_front());
    fire = (hist[0] != hist[1]);
    for (int k = 2; k <= S + 1; k++) if (hist[k] != hist[1]) fire = 0;
    accepted = 0;
    if (fire) begin
      nlow = $countones(~a);
      if (nlow > 1) begin
        m_sel = 1;
      end else if (nlow == 1) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (a[i] == 1'b0) idx = i;
        gv = -1;
        for (int v = 0; v < 16; v++) if (glyph[v] == sg) gv = v;
        if (gv >= 0) begin
          m_dig[idx] = 4'(gv); m_val[idx] = 1; accepted = 1;
        end else if (sg == 7'h7F) begin
          m_val[idx] = 0; accepted = 1;
        end else begin
          m_cerr = 1;
          if (m_err < 255) m_err++;
        end
        if (accepted) begin
          m_cap = 1;
          m_seen[idx] = 1;
          all_seen = m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3];
          if (all_seen) begin
            m_frame = 1;
            for (int i = 0; i < 4; i++) m_seen[i] = 0;
          end
        end
      end
    end
`ifdef SEG7_TIMEOUT_EN
    if (accepted) begin
      m_since = 0; m_stale = 0;
    end else if (!m_stale) begin
      m_since++;
      if (m_since == TO) begin
        m_stale = 1;
        for (int i = 0; i < 4; i++) begin m_val[i] = 0; m_seen[i] = 0; end
      end
    end
`endif
  endtask

  task automatic compare_all();
    logic [15:0] ed;
    logic [3:0]  ev;
    for (int i = 0; i < 4; i++) begin ed[4*i +: 4] = m_dig[i]; ev[i] = m_val[i]; end
    chk("digits", digits, ed);
    chk("digit_valid", digit_valid, ev);
    chk("capture", capture, m_cap);
    chk("frame_done", frame_done, m_frame);
    chk("code_err", code_err, m_cerr);
    chk("sel_err", sel_err, m_sel);
    chk("err_count", err_count, m_err);
    chk("stale", stale, m_stale);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step(rst, seg, an);
      #1;
      if (ready) begin
        compare_all();
        if (capture) cap_cnt++;
        if (frame_done) frame_cnt++;
        if (code_err) cerr_cnt++;
      end
    end
  end

  task automatic drive(input logic [6:0] sg, input logic [3:0] a, input int n);
    seg = sg;
    an  = a;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int c0, f0, e0, dw, k;
    logic [6:0] rs;
    logic [3:0] ra;
    logic [3:0] scan_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] scan_sg [4] = '{7'h40, 7'h79, 7'h24, 7'h30};

    rst = 1'b1; seg = 7'h7F; an = 4'hF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_digits", digits, 16'h0);
    chk("reset_valid", digit_valid, 4'h0);
    chk("reset_err_count", err_count, 8'd0);
    chk("reset_sel_err", sel_err, 1'b0);

    // Single held digit: capture exactly S edges after the change edge.
    c0 = cap_cnt;
    seg = 7'h30; an = 4'hE;
    repeat (S) @(posedge clk);
    #1 chk("t1_no_early_capture", capture, 1'b0);
    @(posedge clk);
    #1 chk("t1_capture_edge", capture, 1'b1);
    chk("t1_digit0", digits[3:0], 4'h3);
    chk("t1_valid", digit_valid, 4'b0001);
    @(negedge clk);
    repeat (10) @(negedge clk);
    chk("t1_single_capture", cap_cnt - c0, 1);

    // Full scan with blank gaps.
    drive(7'h7F, 4'hF, 1);
    c0 = cap_cnt; f0 = frame_cnt;
    for (int i = 0; i < 4; i++) begin
      drive(scan_sg[i], scan_an[i], 8);
      drive(7'h7F, 4'hF, 1);
    end
    chk("t2_digits", digits, 16'h3210);
    chk("t2_valid", digit_valid, 4'hF);
    chk("t2_frames", frame_cnt - f0, 1);
    chk("t2_captures", cap_cnt - c0, 4);

    // Glitchy toggling never settles.
    c0 = cap_cnt;
    for (int i = 0; i < 10; i++) begin
      drive(7'h40, 4'hE, 2);
      drive(7'h79, 4'hE, 2);
    end
    chk("t3_no_capture", cap_cnt - c0, 0);
    chk("t3_digits", digits, 16'h3210);

    // Illegal glyph, then saturation.
    e0 = cerr_cnt;
    drive(7'h7E, 4'hE, 8);
    chk("t4_err_count_1", err_count, 8'd1);
    chk("t4_code_err_once", cerr_cnt - e0, 1);
    for (int i = 0; i < 300; i++) begin
      drive(7'h7F, 4'hF, 1);
      drive(7'h7E, 4'hE, 5);
    end
    chk("t4_err_saturated", err_count, 8'hFF);

    // Multi-select is sticky; blank capture clears valid but keeps value.
    drive(7'h7F, 4'hC, 6);
    chk("t5_sel_err_set", sel_err, 1'b1);
    c0 = cap_cnt;
    drive(7'h40, 4'hE, 6);
    chk("t5_sel_err_sticky", sel_err, 1'b1);
    drive(7'h7F, 4'hE, 6);
    chk("t5_blank_valid0", digit_valid[0], 1'b0);
    chk("t5_blank_holds_value", digits[3:0], 4'h0);
    chk("t5_captures", cap_cnt - c0, 2);

    // Reset in the middle of settling discards the pending capture.
    drive(7'h12, 4'hD, 2);
    rst = 1'b1; seg = 7'h7F; an = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_sel_err_cleared", sel_err, 1'b0);
    chk("t6_err_cleared", err_count, 8'd0);
    c0 = cap_cnt;
    drive(7'h7F, 4'hF, 10);
    chk("t6_no_capture", cap_cnt - c0, 0);
    chk("t6_digits", digits, 16'h0);

`ifdef SEG7_TIMEOUT_EN
    drive(7'h0E, 4'hE, 6);
    chk("t7_digit_f", digits[3:0], 4'hF);
    chk("t7_not_stale", stale, 1'b0);
    drive(7'h7F, 4'hF, 55);
    chk("t7_stale", stale, 1'b1);
    chk("t7_valid_cleared", digit_valid, 4'h0);
    chk("t7_digit_kept", digits[3:0], 4'hF);
    drive(7'h40, 4'hD, 6);
    chk("t7_stale_cleared", stale, 1'b0);
    chk("t7_valid_after", digit_valid, 4'b0010);
`endif

    // Randomized scanning with occasional resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      k = $urandom_range(0, 9);
      if (k < 6)      rs = glyph[$urandom_range(0, 15)];
      else if (k < 8) rs = 7'h7F;
      else            rs = 7'($urandom);
      k = $urandom_range(0, 7);
      if (k < 4)      ra = ~(4'b0001 << k);
      else if (k < 6) ra = 4'hF;
      else            ra = 4'($urandom);
      dw = $urandom_range(1, 8);
      drive(rs, ra, dw);
    end
    drive(7'h7F, 4'hF, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
